rv32i_seq_ctrl: RTL
===================

# rv32i_seq_ctrl

Multi-cycle control sequencer for the RV32I integer datapath. It fetches each instruction over an instruction-memory handshake, decodes it, and drives the datapath controls: FS, the CW4_2 bundle, register addresses and immediate. It sequences word loads and stores through a data-memory handshake and resolves branches from the datapath ZCNV flags. It owns the PC, and together with the datapath, register file and memories it forms the core top level.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1: core clock; all state updates on rising edge.
- rst  in  1: asynchronous, active-high reset.
- o_imem_addr  out  32: current PC.
- o_imem_req  out  1: fetch request, held until i_imem_valid.
- i_imem_valid  in  1: instruction word valid, sampled at the edge.
- i_imem_data  in  32: instruction word.
- o_dmem_req  out  1: data access request, held until i_dmem_ack.
- o_dmem_we  out  1: 1 = store, 0 = load; valid while o_dmem_req.
- i_dmem_ack  in  1: access complete; load data valid on o_data_mem this cycle.
- FS  out  4: function select {funct3, bit30 qualifier}.
- CW4_2  out  3: {s_reg_imm_ALU_B, s_ALU_dmem_wregdata, sig_w_ctrl_reg}.
- o_imm  out  32: sign-extended immediate for the datapath B input.
- r_addr_reg1, r_addr_reg2, w_addr_reg  out  5 each: IR[19:15], IR[24:20], IR[11:7].
- ZCNV  in  4: {Z, C, N, V} from the datapath. C is the carry-out of A+~B+1, so C=1 means A ≥ B unsigned.
- o_illegal  out  1: sticky, set on an unsupported encoding or misaligned branch target.
- o_halted  out  1: high in HALT.

## Operation
- States: FETCH, EXEC, MEM, HALT.
- FETCH:
  - Assert o_imem_req.
  - On i_imem_valid: latch i_imem_data into IR and go to EXEC.
  - Zero-wait memory is legal: valid may arrive in the first request cycle.
- EXEC, by opcode (decode is combinational from IR):
  - R-type (0110011): FS = {f3, IR[30]}; CW4_2 = 3'b001. Go to FETCH; PC += 4.
  - I-ALU (0010011): FS = {f3, f3==101 ? IR[30] : 0}; CW4_2 = 3'b101; o_imm = I-imm. Go to FETCH; PC += 4.
  - LW (0000011, f3 = 010) and SW (0100011, f3 = 010):
    - FS = 0000 (ADD); CW4_2 = 3'b100; o_imm = I-imm for LW, S-imm for SW.
    - Go to MEM.
  - Branch (1100011, f3 ∈ {000, 001, 100, 101, 110, 111}):
    - FS = 0001 (SUB); CW4_2 = 3'b000; o_imm = B-imm.
    - Taken conditions: BEQ Z, BNE ~Z, BLT N^V, BGE ~(N^V), BLTU ~C, BGEU C.
    - Taken: PC = PC + B-imm, using an internal adder. Not taken: PC += 4. Go to FETCH.
    - If taken and the target has bit1 = 1: set o_illegal, go to HALT, PC unchanged.
  - Any other opcode or f3: set o_illegal, go to HALT.
- MEM:
  - Hold FS = 0000 and o_imm, so o_ALU stays a stable address.
  - Assert o_dmem_req; o_dmem_we = 1 for SW.
  - On i_dmem_ack:
    - LW: CW4_2 = 3'b111 that cycle (register write).
    - SW: CW4_2 = 3'b100.
    - Then go to FETCH; PC += 4.
  - Before ack, CW4_2 = 3'b100.
- Write suppression: sig_w_ctrl_reg is forced to 0 when w_addr_reg == 0.
- HALT: terminal until rst. All requests and writes are 0.
- PC arithmetic is mod 2^32; wrap-around at 32'hFFFF_FFFC → 0 is silent.

## Timing
- Reset values: state FETCH, PC = RESET_PC, IR = 0.
  - o_imem_req = 0 during reset, then 1 from the first cycle after release.
  - o_dmem_req, o_dmem_we, CW4_2, FS, o_imm, addresses, o_illegal and o_halted are all 0.
- Latency, with fetch wait W (W = 0 is allowed):
  - ALU ops and branches: 2 + W cycles.
  - LW/SW: 3 + W + D cycles, where D is the data-ack wait.
- Register write occurs on the clock edge closing EXEC (ALU ops) or closing the ack cycle (LW).
- o_dmem_req rises on the edge entering MEM and falls on the edge after ack; acks outside MEM are ignored.
- rst during MEM or FETCH drops all requests immediately (asynchronous) with no register write.

## Structure
- Package rv32i_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - the state enum;
  - FS_ADD = 4'b0000 and FS_SUB = 4'b0001;
  - the CW4_2 bundle bit positions.
- Sub-module imm_gen: combinational selection of I, S and B immediates from IR plus a select input.
- The FSM, PC, IR and branch resolver live in the top module.

## Test plan
- ADDI x1, x0, 5 with W = 0: FS = 0000, CW4_2 = 101, o_imm = 5, w_addr_reg = 1. Next fetch address is RESET_PC + 4 after 2 cycles.
- SUB x3, x1, x2 then ADDI x5, x0, 0 (rd = 0 case uses ADDI x0, x0, 1): FS = 0001, CW4_2 = 001; for rd = 0, sig_w_ctrl_reg = 0.
- LW x4, 8(x1) with i_dmem_ack after 3 cycles: o_dmem_req high 4 cycles, o_dmem_we = 0, CW4_2 = 111 only in the ack cycle, FS held at 0000.
- BEQ with Z = 1 and B-imm = −8 at PC = 0x20: next PC = 0x18. With Z = 0: next PC = 0x24. BLTU with C = 0: taken.
- Opcode 0110111 (LUI): o_illegal = 1 and o_halted = 1 on the next cycle; no further o_imem_req.
- rst asserted two cycles into MEM: o_dmem_req = 0 asynchronously, PC = RESET_PC, no register write; fetch restarts after release.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv32i_pkg
//  Description : Shared encodings for the RV32I multi-cycle control sequencer.
//                This package holds the opcodes, the sequencer state encoding,
//                the immediate-format select, the ALU function selects and the
//                CW4_2 bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_WORD   = 3'b010;

   localparam logic [3:0] FS_ADD    = 4'b0000;
   localparam logic [3:0] FS_SUB    = 4'b0001;

   // CW4_2 = {s_reg_imm_ALU_B, s_ALU_dmem_wregdata, sig_w_ctrl_reg}
   localparam int CW_ALU_B_IMM = 2;
   localparam int CW_WDATA_MEM = 1;
   localparam int CW_WREG      = 0;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I    = 2'd1,
      IMM_S    = 2'd2,
      IMM_B    = 2'd3
   } imm_sel_e;

endpackage
`default_nettype wire

// File: rtl/rv32i_seq_ctrl_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational sign-extended immediate selection (I, S, B).
//  Ports       : ir_hi_i - IR[31:20]
//                ir_lo_i - IR[11:7]
//                sel_i   - immediate format select (IMM_NONE gives 0)
//                imm_o   - 32-bit sign-extended immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
   import rv32i_pkg::*;
(
   input  logic [11:0] ir_hi_i,
   input  logic [4:0]  ir_lo_i,
   input  imm_sel_e    sel_i,
   output logic [31:0] imm_o
);

   // ir_hi_i[11] is IR[31], the sign bit of every format.
   always_comb begin
      imm_o = 32'd0;
      case (sel_i)
         IMM_I:   imm_o = {{20{ir_hi_i[11]}}, ir_hi_i};
         IMM_S:   imm_o = {{20{ir_hi_i[11]}}, ir_hi_i[11:5], ir_lo_i};
         IMM_B:   imm_o = {{20{ir_hi_i[11]}}, ir_lo_i[0], ir_hi_i[10:5],
                           ir_lo_i[4:1], 1'b0};
         default: imm_o = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rv32i_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_seq_ctrl
//  Description : Multi-cycle RV32I control sequencer. It fetches over an imem
//                handshake, decodes the IR and drives the datapath controls,
//                sequences LW/SW over a dmem handshake, resolves branches from
//                ZCNV and owns the PC.
//  Ports       : clk/rst            - clock, async active-high reset
//                o_imem_*/i_imem_*  - instruction fetch handshake
//                o_dmem_*/i_dmem_*  - data access handshake
//                FS, CW4_2, o_imm   - datapath function / control / immediate
//                r_addr_reg1/2, w_addr_reg - register addresses from the IR
//                ZCNV               - datapath flags {Z, C, N, V}
//                o_illegal, o_halted - sticky fault flag and halt indication
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_seq_ctrl
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] o_imem_addr,
   output logic        o_imem_req,
   input  logic        i_imem_valid,
   input  logic [31:0] i_imem_data,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   input  logic        i_dmem_ack,
   output logic [3:0]  FS,
   output logic [2:0]  CW4_2,
   output logic [31:0] o_imm,
   output logic [4:0]  r_addr_reg1,
   output logic [4:0]  r_addr_reg2,
   output logic [4:0]  w_addr_reg,
   input  logic [3:0]  ZCNV,
   output logic        o_illegal,
   output logic        o_halted
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        illegal_q, illegal_d;

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic        w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br;
   logic        w_taken;
   logic [31:0] w_pc_plus4, w_br_target;
   logic [3:0]  w_fs;
   logic [2:0]  w_cw;
   imm_sel_e    w_imm_sel;
   logic        w_imem_req, w_dmem_req, w_dmem_we;

   // ---------------------------------------------------------------- decode
   assign w_opcode = ir_q[6:0];
   assign w_f3     = ir_q[14:12];
   assign w_is_r   = (w_opcode == OP_R);
   assign w_is_i   = (w_opcode == OP_I);
   assign w_is_lw  = (w_opcode == OP_LOAD)  && (w_f3 == F3_WORD);
   assign w_is_sw  = (w_opcode == OP_STORE) && (w_f3 == F3_WORD);
   // f3 = 010/011 are not branch encodings
   assign w_is_br  = (w_opcode == OP_BRANCH) && (w_f3[2:1] != 2'b01);

   // ZCNV = {Z, C, N, V}; C set means A >= B unsigned.
   always_comb begin
      w_taken = 1'b0;
      case (w_f3)
         3'b000:  w_taken =  ZCNV[3];
         3'b001:  w_taken = ~ZCNV[3];
         3'b100:  w_taken =  ZCNV[1] ^ ZCNV[0];
         3'b101:  w_taken = ~(ZCNV[1] ^ ZCNV[0]);
         3'b110:  w_taken = ~ZCNV[2];
         3'b111:  w_taken =  ZCNV[2];
         default: w_taken = 1'b0;
      endcase
   end

   imm_gen u_imm_gen (
      .ir_hi_i (ir_q[31:20]),
      .ir_lo_i (ir_q[11:7]),
      .sel_i   (w_imm_sel),
      .imm_o   (o_imm)
   );

   // o_imm carries the B-immediate whenever a branch is in EXEC
   assign w_pc_plus4  = pc_q + 32'd4;
   assign w_br_target = pc_q + o_imm;

   // --------------------------------------------------------- state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (i_imem_valid) begin
               ir_d    = i_imem_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_is_r || w_is_i) begin
               pc_d    = w_pc_plus4;
               state_d = S_FETCH;
            end else if (w_is_lw || w_is_sw) begin
               state_d = S_MEM;
            end else if (w_is_br) begin
               // A taken branch to a non-word-aligned target faults in place.
               if (w_taken && w_br_target[1]) begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end else begin
                  pc_d    = w_taken ? w_br_target : w_pc_plus4;
                  state_d = S_FETCH;
               end
            end else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_MEM: begin
            if (i_dmem_ack) begin
               pc_d    = w_pc_plus4;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      w_fs       = FS_ADD;
      w_cw       = 3'b000;
      w_imm_sel  = IMM_NONE;
      w_imem_req = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      case (state_q)
         S_FETCH: w_imem_req = 1'b1;
         S_EXEC: begin
            if (w_is_r) begin
               w_fs = {w_f3, ir_q[30]};
               w_cw = 3'b001;
            end else if (w_is_i) begin
               // IR[30] only qualifies the shift-right immediates
               w_fs      = {w_f3, (w_f3 == 3'b101) ? ir_q[30] : 1'b0};
               w_cw      = 3'b101;
               w_imm_sel = IMM_I;
            end else if (w_is_lw || w_is_sw) begin
               w_cw      = 3'b100;
               w_imm_sel = w_is_sw ? IMM_S : IMM_I;
            end else if (w_is_br) begin
               w_fs      = FS_SUB;
               w_imm_sel = IMM_B;
            end
         end
         S_MEM: begin
            // Address stays stable: ADD with the same immediate as EXEC.
            w_imm_sel  = w_is_sw ? IMM_S : IMM_I;
            w_dmem_req = 1'b1;
            w_dmem_we  = w_is_sw;
            w_cw       = (i_dmem_ack && w_is_lw) ? 3'b111 : 3'b100;
         end
         default: ;
      endcase
   end

   assign o_imem_addr = pc_q;
   // state_q already reads FETCH during reset; gate so no fetch is requested.
   assign o_imem_req  = w_imem_req & ~rst;
   assign o_dmem_req  = w_dmem_req & ~rst;
   assign o_dmem_we   = w_dmem_we  & ~rst;
   assign FS          = w_fs;
   assign CW4_2       = {w_cw[CW_ALU_B_IMM], w_cw[CW_WDATA_MEM],
                         w_cw[CW_WREG] & (w_addr_reg != 5'd0)};
   assign r_addr_reg1 = ir_q[19:15];
   assign r_addr_reg2 = ir_q[24:20];
   assign w_addr_reg  = ir_q[11:7];
   assign o_illegal   = illegal_q;
   assign o_halted    = (state_q == S_HALT);

endmodule
`default_nettype wire
